div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arb_pkg.sv | 21 ++
 rtl/div_rr_pick.sv | 46 ++++
 rtl/div_arbiter.sv | 178 +++++++++++++++++
 tb/tb_div_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider arbiter.
//   - FSM state enum for div_arbiter
//   - default NUM_REQ / DATA_W values
//   - idx_width(): index width for an n-entry requester vector
package div_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned DATA_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Ports:
//   req_i   - request vector
//   ptr_i   - highest-priority index this cycle
//   grant_o - one-hot grant (zero when no request)
//   idx_o   - index of the grant
//   any_o   - at least one request present
module div_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

  // One spare bit so ptr + offset can exceed NUM_REQ before wrapping.
  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    cand    = '0;
    found   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
    any_o = found;
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider among NUM_REQ requesters, one divide in flight.
// Optional build macro: DIV_ARB_ZERO_BYPASS_EN -- a zero divisor is answered locally
// (quotient all-ones, remainder = dividend, rsp_err = 1) without starting the divider.
// Ports:
//   ACLK, ARESET                 - clock, synchronous active-high reset
//   req_valid/req_ready          - per-requester request / one-hot accept pulse
//   req_dividend/req_divisor     - packed operands, requester i at slice i
//   rsp_valid                    - one-hot result strobe
//   rsp_quotient/remainder/err   - result, held between strobes
//   div_start/dividend/divisor   - command to the shared divider
//   div_done/quotient/remainder  - completion from the shared divider
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic                      rsp_err,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_remainder
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  dvd_q, dvd_d;
  logic [DATA_W-1:0]  dvs_q, dvs_d;
  logic [DATA_W-1:0]  quo_q, quo_d;
  logic [DATA_W-1:0]  rem_q, rem_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  dvd_arr [NUM_REQ];
  logic [DATA_W-1:0]  dvs_arr [NUM_REQ];
  logic [DATA_W-1:0]  sel_dvd, sel_dvs;

  div_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dvd_arr[i] = req_dividend[i*DATA_W +: DATA_W];
      dvs_arr[i] = req_divisor[i*DATA_W +: DATA_W];
    end
  end

  assign sel_dvd = dvd_arr[pick_idx];
  assign sel_dvs = dvs_arr[pick_idx];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          req_ready = pick_grant;
          grant_d   = pick_idx;
          dvd_d     = sel_dvd;
          dvs_d     = sel_dvs;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (sel_dvs == '0) begin
            quo_d   = '1;
            rem_d   = sel_dvd;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (div_done) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end
      end
      StResp: begin
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // No accept may be seen while reset is being applied.
    if (ARESET) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[grant_q] = 1'b1;
    end
  end

  assign div_start     = (state_q == StIssue);
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign rsp_err       = err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter (NUM_REQ=4, DATA_W=32).
// Inputs change #1 after the rising edge; outputs are observed on the falling edge.
module tb_div_arbiter;

  logic         ACLK;
  logic         ARESET;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_dividend;
  logic [127:0] req_divisor;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_quotient;
  logic [31:0]  rsp_remainder;
  logic         rsp_err;
  logic         div_start;
  logic [31:0]  div_dividend;
  logic [31:0]  div_divisor;
  logic         div_done;
  logic [31:0]  div_quotient;
  logic [31:0]  div_remainder;

  logic         model_done;
  logic         stray_done;
  logic         model_en;
  int           dly;
  logic [3:0]   hold;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         acc_idx[$];
  int         acc_cyc[$];
  logic [3:0] rsp_vec[$];
  logic [31:0] rsp_qq[$];
  logic [31:0] rsp_rr[$];
  logic       rsp_ee[$];
  int         rsp_cyc[$];
  int         n_start;
  int         start_cyc;

  assign div_done = model_done | stray_done;

  div_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (32)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  // Divider model: result dly cycles after the start cycle, one-cycle done pulse.
  initial begin
    logic [31:0] a, b;
    model_done    = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    forever begin
      @(negedge ACLK);
      if (model_en && div_start) begin
        a = div_dividend;
        b = div_divisor;
        repeat (dly) @(posedge ACLK);
        #1;
        if (b == 0) begin
          div_quotient  = 32'hFFFF_FFFF;
          div_remainder = a;
        end else begin
          div_quotient  = a / b;
          div_remainder = a % b;
        end
        model_done = 1'b1;
        @(posedge ACLK);
        #1 model_done = 1'b0;
      end
    end
  end

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    acc_idx.delete(); acc_cyc.delete();
    rsp_vec.delete(); rsp_qq.delete(); rsp_rr.delete(); rsp_ee.delete(); rsp_cyc.delete();
    n_start = 0;
    start_cyc = -1;
  endtask

  // One clock: log outputs at the falling edge, drop accepted requests after the rise.
  task automatic step();
    logic [3:0] accepted;
    @(negedge ACLK);
    if (req_ready != 4'b0) begin
      acc_idx.push_back(oh_idx(req_ready));
      acc_cyc.push_back(cyc);
    end
    if (div_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (rsp_valid != 4'b0) begin
      rsp_vec.push_back(rsp_valid);
      rsp_qq.push_back(rsp_quotient);
      rsp_rr.push_back(rsp_remainder);
      rsp_ee.push_back(rsp_err);
      rsp_cyc.push_back(cyc);
    end
    accepted = req_ready & ~hold;
    @(posedge ACLK);
    #1 req_valid = req_valid & ~accepted;
  endtask

  task automatic set_ops(int i, logic [31:0] dvd, logic [31:0] dvs);
    req_dividend[i*32 +: 32] = dvd;
    req_divisor[i*32 +: 32]  = dvs;
  endtask

  task automatic wait_rsp(int n, int budget, string name);
    int k = 0;
    while (rsp_vec.size() < n && k < budget) begin
      step();
      k++;
    end
    if (rsp_vec.size() < n) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d responses, need %0d", name, rsp_vec.size(), n);
    end
  endtask

  task automatic test_reset();
    ARESET    = 1'b1;
    req_valid = 4'hF;
    step();
    step();
    total++;
    if (req_ready !== 4'b0) begin
      bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    total++;
    if ({rsp_valid, div_start, rsp_err} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000", {rsp_valid, div_start, rsp_err});
    end
    total++;
    if ({rsp_quotient, rsp_remainder, div_dividend, div_divisor} !== 128'b0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               rsp_quotient, rsp_remainder, div_dividend, div_divisor);
    end
    req_valid = 4'b0;
    ARESET    = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_logs();
    dly = 5;
    set_ops(1, 32'd100, 32'd7);
    req_valid = 4'b0010;
    wait_rsp(1, 60, "single");
    repeat (3) step();
    total++;
    if (n_start !== 1) begin
      bad++; $display("FAIL single_start_count: got %0d want 1", n_start);
    end
    if (rsp_vec.size() == 1 && acc_cyc.size() == 1) begin
      total++;
      if (rsp_vec[0] !== 4'b0010) begin
        bad++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_vec[0]);
      end
      total++;
      if (rsp_qq[0] !== 32'd14 || rsp_rr[0] !== 32'd2) begin
        bad++; $display("FAIL single_result: got q=%0d r=%0d want q=14 r=2", rsp_qq[0], rsp_rr[0]);
      end
      total++;
      if (start_cyc !== acc_cyc[0] + 1) begin
        bad++; $display("FAIL single_start_lat: got %0d want %0d", start_cyc, acc_cyc[0] + 1);
      end
      total++;
      if (rsp_cyc[0] !== start_cyc + 6) begin
        bad++; $display("FAIL single_rsp_lat: got %0d want %0d", rsp_cyc[0], start_cyc + 6);
      end
    end
    total++;
    if (rsp_quotient !== 32'd14 || rsp_remainder !== 32'd2) begin
      bad++;
      $display("FAIL single_hold: got q=%0d r=%0d want q=14 r=2", rsp_quotient, rsp_remainder);
    end
  endtask

  task automatic test_round_robin();
    int exp_q [4] = '{333, 7, 71, 2};
    int exp_r [4] = '{1, 7, 3, 1};
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    clear_logs();
    dly = 2;
    set_ops(0, 32'd1000, 32'd3);
    set_ops(1, 32'd77,   32'd10);
    set_ops(2, 32'd500,  32'd7);
    set_ops(3, 32'd9,    32'd4);
    hold      = 4'hF;
    req_valid = 4'hF;
    wait_rsp(5, 200, "rr");
    hold      = 4'h0;
    req_valid = 4'h0;
    repeat (10) step();
    if (rsp_vec.size() == 5 && acc_idx.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (acc_idx[k] !== k % 4 || rsp_vec[k] !== 4'(1 << (k % 4))) begin
          bad++;
          $display("FAIL rr_order_%0d: got grant %0d rsp %b want %0d", k, acc_idx[k], rsp_vec[k],
                   k % 4);
        end
        total++;
        if (rsp_qq[k] !== 32'(exp_q[k%4]) || rsp_rr[k] !== 32'(exp_r[k%4])) begin
          bad++;
          $display("FAIL rr_result_%0d: got q=%0d r=%0d want q=%0d r=%0d", k, rsp_qq[k], rsp_rr[k],
                   exp_q[k%4], exp_r[k%4]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (acc_cyc[k+1] !== rsp_cyc[k] + 1) begin
          bad++;
          $display("FAIL rr_gap_%0d: got accept at %0d want %0d", k, acc_cyc[k+1], rsp_cyc[k] + 1);
        end
      end
    end else begin
      total++; bad++;
      $display("FAIL rr_counts: got %0d accepts %0d responses want 5 5", acc_idx.size(),
               rsp_vec.size());
    end
  endtask

  task automatic test_zero_divisor();
    clear_logs();
    dly = 3;
    set_ops(2, 32'h55, 32'h0);
    req_valid = 4'b0100;
    wait_rsp(1, 40, "zero");
    repeat (3) step();
    if (rsp_vec.size() == 1 && acc_cyc.size() == 1) begin
      total++;
      if (rsp_vec[0] !== 4'b0100) begin
        bad++; $display("FAIL zero_rsp_valid: got %b want 0100", rsp_vec[0]);
      end
      total++;
      if (rsp_qq[0] !== 32'hFFFF_FFFF || rsp_rr[0] !== 32'h55) begin
        bad++; $display("FAIL zero_result: got q=%h r=%h want ffffffff 55", rsp_qq[0], rsp_rr[0]);
      end
`ifdef DIV_ARB_ZERO_BYPASS_EN
      total++;
      if (rsp_ee[0] !== 1'b1) begin
        bad++; $display("FAIL zero_err: got %b want 1", rsp_ee[0]);
      end
      total++;
      if (n_start !== 0) begin
        bad++; $display("FAIL zero_no_start: got %0d starts want 0", n_start);
      end
      total++;
      if (rsp_cyc[0] !== acc_cyc[0] + 1) begin
        bad++; $display("FAIL zero_lat: got %0d want %0d", rsp_cyc[0], acc_cyc[0] + 1);
      end
`else
      total++;
      if (rsp_ee[0] !== 1'b0) begin
        bad++; $display("FAIL zero_err: got %b want 0", rsp_ee[0]);
      end
      total++;
      if (n_start !== 1) begin
        bad++; $display("FAIL zero_forwarded: got %0d starts want 1", n_start);
      end
`endif
    end
  endtask

  task automatic test_idle_done();
    clear_logs();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (4) step();
    total++;
    if (rsp_vec.size() !== 0 || acc_idx.size() !== 0 || n_start !== 0) begin
      bad++;
      $display("FAIL idle_done_activity: got rsp=%0d acc=%0d start=%0d want 0 0 0",
               rsp_vec.size(), acc_idx.size(), n_start);
    end
    total++;
    if (rsp_quotient !== 32'hFFFF_FFFF || rsp_remainder !== 32'h55) begin
      bad++;
      $display("FAIL idle_done_hold: got q=%h r=%h want ffffffff 55", rsp_quotient, rsp_remainder);
    end
  endtask

  task automatic test_reset_in_wait();
    int k = 0;
    clear_logs();
    model_en = 1'b0;
    set_ops(2, 32'd40, 32'd6);
    req_valid = 4'b0100;
    while (n_start == 0 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (n_start !== 1) begin
      bad++; $display("FAIL rstwait_start: got %0d starts want 1", n_start);
    end
    step();
    step();
    ARESET    = 1'b1;
    req_valid = 4'b0;
    step();
    ARESET = 1'b0;
    step();
    total++;
    if ({rsp_quotient, rsp_remainder, div_dividend, div_divisor, rsp_err, div_start} !== 130'b0) begin
      bad++;
      $display("FAIL rstwait_outputs: got %h %h %h %h %b %b want all 0", rsp_quotient,
               rsp_remainder, div_dividend, div_divisor, rsp_err, div_start);
    end
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (3) step();
    total++;
    if (rsp_vec.size() !== 0) begin
      bad++; $display("FAIL rstwait_no_rsp: got %0d responses want 0", rsp_vec.size());
    end
    clear_logs();
    model_en = 1'b1;
    dly = 3;
    set_ops(0, 32'd50, 32'd5);
    set_ops(3, 32'd31, 32'd8);
    req_valid = 4'b1001;
    wait_rsp(2, 100, "rstwait_next");
    if (acc_idx.size() == 2 && rsp_vec.size() == 2) begin
      total++;
      if (acc_idx[0] !== 0 || acc_idx[1] !== 3) begin
        bad++; $display("FAIL rstwait_ptr: got order %0d,%0d want 0,3", acc_idx[0], acc_idx[1]);
      end
      total++;
      if (rsp_qq[0] !== 32'd10 || rsp_rr[1] !== 32'd7) begin
        bad++; $display("FAIL rstwait_results: got q0=%0d r3=%0d want 10 7", rsp_qq[0], rsp_rr[1]);
      end
    end
  endtask

  task automatic test_drop();
    int k = 0;
    clear_logs();
    dly = 4;
    set_ops(0, 32'd20, 32'd3);
    set_ops(3, 32'd99, 32'd9);
    req_valid = 4'b0001;
    while (acc_idx.size() == 0 && k < 20) begin
      step();
      k++;
    end
    req_valid[3] = 1'b1;
    step();
    step();
    req_valid[3] = 1'b0;
    wait_rsp(1, 40, "drop");
    repeat (8) step();
    total++;
    if (acc_idx.size() !== 1 || rsp_vec.size() !== 1) begin
      bad++;
      $display("FAIL drop_counts: got acc=%0d rsp=%0d want 1 1", acc_idx.size(), rsp_vec.size());
    end else begin
      total++;
      if (rsp_vec[0] !== 4'b0001 || rsp_qq[0] !== 32'd6 || rsp_rr[0] !== 32'd2) begin
        bad++;
        $display("FAIL drop_rsp: got %b q=%0d r=%0d want 0001 6 2", rsp_vec[0], rsp_qq[0],
                 rsp_rr[0]);
      end
    end
  endtask

  initial begin
    ARESET       = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    stray_done   = 1'b0;
    model_en     = 1'b1;
    dly          = 5;
    hold         = '0;
    clear_logs();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_divisor();
    test_idle_done();
    test_reset_in_wait();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
